// File: rtl/shift_seq_ctrl_if.sv
// Serial self-check bus between shift_seq_ctrl and whoever drives/observes it.
// The master side supplies START/PATTERN and the datapath Q; the slave side is the sequencer.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic [WIDTH-1:0] PATTERN;
  logic             D;
  logic             Q;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] RESULT;
  logic             MATCH;

  modport master (
    output START, PATTERN, Q,
    input  D, BUSY, DONE, RESULT, MATCH
  );

  modport slave (
    input  START, PATTERN, Q,
    output D, BUSY, DONE, RESULT, MATCH
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Drives a latched pattern MSB-first onto a fixed-latency serial datapath,
// recaptures it after DEPTH edges and reports the word and a compare result.
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic              CK,
  input  logic              RST,
  shift_seq_ctrl_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + DEPTH + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FIRST_CAP  = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_CAP   = CW'(WIDTH + DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_pat;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_result;
  logic             r_done;
  logic             r_match;

  logic             w_accept;
  logic             w_capture;
  logic             w_last;
  logic [WIDTH-1:0] w_cap_word;

  assign w_accept   = (r_state == S_IDLE) && bus.START;
  assign w_capture  = (r_state != S_IDLE) && (r_cnt >= FIRST_CAP);
  assign w_last     = (r_state == S_FLUSH) && (r_cnt == LAST_CAP);
  assign w_cap_word = {r_result[WIDTH-2:0], bus.Q};

  always_ff @(posedge CK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.START)          w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == LAST_SHIFT) w_next = S_FLUSH;
      S_FLUSH: if (r_cnt == LAST_CAP)   w_next = S_IDLE;
      default:                          w_next = S_IDLE;
    endcase
  end

  // r_sh empties to zero as it shifts, so D is 0 through FLUSH and IDLE.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r_cnt    <= '0;
      r_pat    <= '0;
      r_sh     <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_match  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_pat    <= bus.PATTERN;
        r_sh     <= bus.PATTERN;
        r_cnt    <= '0;
        r_result <= '0;
        r_match  <= 1'b0;
      end else if (r_state != S_IDLE) begin
        r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
        r_cnt <= r_cnt + 1'b1;
        if (w_capture) r_result <= w_cap_word;
        if (w_last) begin
          r_done  <= 1'b1;
          r_match <= (w_cap_word == r_pat);
        end
      end
    end
  end

  assign bus.D      = r_sh[WIDTH-1];
  assign bus.BUSY   = (r_state != S_IDLE);
  assign bus.DONE   = r_done;
  assign bus.RESULT = r_result;
  assign bus.MATCH  = r_match;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Randomized bench for shift_seq_ctrl against a serial-stream reference model
// with a configurable-latency / stuck-at datapath model on Q.
module tb_shift_seq_ctrl;

  localparam int W = 8;
  localparam int D = 2;
  localparam int SEQ = W + D;

  logic CK;
  logic RST;
  int   n_cmp;
  int   n_bad;

  int   dp_lat;
  bit   dp_stuck;
  logic dp1, dp2;

  shift_seq_ctrl_if #(.WIDTH(W)) bus ();

  shift_seq_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .CK  (CK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Datapath stand-in: not reset, so stale bits survive a mid-sequence RST.
  always @(posedge CK) begin
    dp1 <= bus.D;
    dp2 <= dp1;
  end
  assign bus.Q = dp_stuck ? 1'b0 : ((dp_lat == 1) ? dp1 : dp2);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Serial stream view: D carries pattern bits then zeros; Q is D delayed by lat cycles.
  function automatic logic [W-1:0] model_result(input logic [W-1:0] pat, input int lat, input bit stuck);
    logic [W-1:0] res;
    logic         dstream [SEQ];
    for (int c = 0; c < SEQ; c++) dstream[c] = (c < W) ? pat[W-1-c] : 1'b0;
    res = '0;
    for (int c = D; c < SEQ; c++) res = {res[W-2:0], (stuck ? 1'b0 : dstream[c-lat])};
    return res;
  endfunction

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".D"},      32'(bus.D),      32'd0);
    chk({tag, ".BUSY"},   32'(bus.BUSY),   32'd0);
    chk({tag, ".DONE"},   32'(bus.DONE),   32'd0);
    chk({tag, ".RESULT"}, 32'(bus.RESULT), 32'd0);
    chk({tag, ".MATCH"},  32'(bus.MATCH),  32'd0);
  endtask

  // One full sequence. prestarted: E0 is the next posedge (START already high).
  // keep_start/next_pat: leave START high in the DONE cycle to chain another run.
  task automatic run_seq(input logic [W-1:0] pat, input bit prestarted, input bit noise,
                         input bit keep_start, input logic [W-1:0] next_pat);
    logic [W-1:0] exp_res;
    exp_res = model_result(pat, dp_lat, dp_stuck);
    if (!prestarted) begin
      @(negedge CK);
      bus.START   = 1'b1;
      bus.PATTERN = pat;
    end
    @(posedge CK);
    for (int c = 0; c <= SEQ; c++) begin
      @(negedge CK);
      if (c < SEQ) begin
        bus.START   = noise ? 1'($urandom_range(0, 1)) : keep_start;
        bus.PATTERN = noise ? W'($urandom) : pat;
      end else begin
        bus.START   = keep_start;
        bus.PATTERN = next_pat;
      end
      chk($sformatf("D[c%0d]", c),    32'(bus.D),    32'((c < W) ? pat[W-1-c] : 1'b0));
      chk($sformatf("BUSY[c%0d]", c), 32'(bus.BUSY), 32'(c < SEQ));
      chk($sformatf("DONE[c%0d]", c), 32'(bus.DONE), 32'(c == SEQ));
    end
    chk("RESULT", 32'(bus.RESULT), 32'(exp_res));
    chk("MATCH",  32'(bus.MATCH),  32'(exp_res == pat));
  endtask

  initial begin
    logic [W-1:0] p;
    n_cmp       = 0;
    n_bad       = 0;
    dp_lat      = 2;
    dp_stuck    = 1'b0;
    RST         = 1'b1;
    bus.START   = 1'b0;
    bus.PATTERN = '0;
    repeat (2) @(negedge CK);
    chk_idle_zero("rst");
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CK);
      chk_idle_zero("idle");
    end

    run_seq(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);
    dp_stuck = 1'b1;
    run_seq(8'hFF, 1'b0, 1'b0, 1'b0, 8'h00);
    dp_stuck = 1'b0;
    dp_lat   = 1;
    run_seq(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);
    dp_lat   = 2;

    // START/PATTERN noise while busy, then START held through DONE for a chained run.
    run_seq(8'hA5, 1'b0, 1'b1, 1'b1, 8'h3C);
    run_seq(8'h3C, 1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge CK);
    chk("DONE.after_chain", 32'(bus.DONE), 32'd0);

    // Asynchronous reset in the middle of cycle 5.
    @(negedge CK);
    bus.START   = 1'b1;
    bus.PATTERN = 8'hC3;
    @(posedge CK);
    @(negedge CK);
    bus.START = 1'b0;
    repeat (5) @(posedge CK);
    #2;
    RST = 1'b1;
    #1;
    chk_idle_zero("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge CK);
      chk_idle_zero("inrst");
    end
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CK);
      chk_idle_zero("postrst");
    end
    run_seq(8'h81, 1'b0, 1'b0, 1'b0, 8'h00);

    for (int k = 0; k < 20; k++) begin
      dp_lat   = int'($urandom_range(1, 2));
      dp_stuck = ($urandom_range(0, 7) == 0);
      p        = W'($urandom);
      run_seq(p, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
      repeat ($urandom_range(0, 2)) @(negedge CK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
